counter_monitor: RTL and testbench

Online checker that sits on the output side of the 4-bit up/down counter and verifies its count stream cycle by cycle. It samples the counter's control inputs and count output, predicts each next value, and flags mismatches. It keeps a saturating error tally and latches a sticky fault after repeated consecutive errors. It is the consumer of the counter interface: it is instantiated beside the counter in the design and in benches as a self-checking monitor.

---
 rtl/counter_monitor.sv | 125 ++++++++++++
 tb/tb_counter_monitor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_monitor.sv
// Checks an up/down counter's output stream cycle by cycle and keeps a saturating error tally and a sticky fault.
// Latency: one cycle from the sampled count to mismatch/wrap pulses. No backpressure; samples every clk.
// Optional wrap pulses are built only when COUNTER_MONITOR_WRAP_EN is defined.
module counter_monitor #(
  parameter int WIDTH       = 4,
  parameter int ERR_W       = 8,
  parameter int FAULT_LIMIT = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             up_down,
  input  logic [WIDTH-1:0] count,
  input  logic             clear,
  output logic             locked,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic             fault,
  output logic             wrap_up,
  output logic             wrap_down
);

  localparam logic [1:0]       SYNC         = 2'd0;
  localparam logic [1:0]       TRACK        = 2'd1;
  localparam logic [1:0]       FAULT        = 2'd2;
  localparam logic [3:0]       CONSEC_LIMIT = 4'(FAULT_LIMIT);
  localparam logic [ERR_W-1:0] ERR_MAX      = '1;

  logic [1:0]       state;
  logic [WIDTH-1:0] prev_count;
  logic             prev_en;
  logic             prev_ud;
  logic [3:0]       consec;
  logic [3:0]       consec_inc;
  logic [WIDTH-1:0] expected;
  logic             miss;

  always_comb begin
    expected = prev_count;
    if (prev_en) begin
      expected = prev_ud ? prev_count + WIDTH'(1) : prev_count - WIDTH'(1);
    end
  end

  assign miss       = (state == TRACK) && (count != expected);
  assign consec_inc = consec + 4'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SYNC;
      prev_count <= '0;
      prev_en    <= 1'b0;
      prev_ud    <= 1'b0;
      consec     <= '0;
      err_count  <= '0;
      mismatch   <= 1'b0;
      locked     <= 1'b0;
      fault      <= 1'b0;
    end else if (clear) begin
      // clear wins over any mismatch sampled on the same edge
      state     <= SYNC;
      consec    <= '0;
      err_count <= '0;
      mismatch  <= 1'b0;
      locked    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      mismatch <= miss;
      if (state != FAULT) begin
        prev_count <= count;
        prev_en    <= enable;
        prev_ud    <= up_down;
      end
      case (state)
        SYNC: begin
          state  <= TRACK;
          locked <= 1'b1;
        end
        TRACK: begin
          if (miss) begin
            if (err_count != ERR_MAX) err_count <= err_count + ERR_W'(1);
            consec <= consec_inc;
            if (consec_inc == CONSEC_LIMIT) begin
              state  <= FAULT;
              locked <= 1'b0;
              fault  <= 1'b1;
            end
          end else begin
            consec <= '0;
          end
        end
        FAULT: begin
        end
        default: begin
          state  <= SYNC;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef COUNTER_MONITOR_WRAP_EN
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic track_ok;
  assign track_ok = (state == TRACK) && !miss && prev_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrap_up   <= 1'b0;
      wrap_down <= 1'b0;
    end else if (clear) begin
      wrap_up   <= 1'b0;
      wrap_down <= 1'b0;
    end else begin
      wrap_up   <= track_ok &&  prev_ud && (prev_count == CNT_MAX) && (count == '0);
      wrap_down <= track_ok && !prev_ud && (prev_count == '0) && (count == CNT_MAX);
    end
  end
`else
  assign wrap_up   = 1'b0;
  assign wrap_down = 1'b0;
`endif

endmodule

// File: tb/tb_counter_monitor.sv
// Bench for counter_monitor: a spec-level reference model pushes expected outputs per edge, popped and compared after the edge.
module tb_counter_monitor;

`ifdef COUNTER_MONITOR_WRAP_EN
  localparam bit WRAP_ON = 1'b1;
`else
  localparam bit WRAP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n, enable, up_down, clear;
  logic [3:0] count;
  logic       locked, mismatch, fault, wrap_up, wrap_down;
  logic [7:0] err_count;
  logic       locked_s, mismatch_s, fault_s, wrap_up_s, wrap_down_s;
  logic [1:0] err_count_s;

  always #5 clk = ~clk;

  counter_monitor #(.WIDTH(4), .ERR_W(8), .FAULT_LIMIT(3)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up_down(up_down), .count(count),
    .clear(clear), .locked(locked), .mismatch(mismatch), .err_count(err_count),
    .fault(fault), .wrap_up(wrap_up), .wrap_down(wrap_down)
  );

  counter_monitor #(.WIDTH(4), .ERR_W(2), .FAULT_LIMIT(3)) dut_sat (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up_down(up_down), .count(count),
    .clear(clear), .locked(locked_s), .mismatch(mismatch_s), .err_count(err_count_s),
    .fault(fault_s), .wrap_up(wrap_up_s), .wrap_down(wrap_down_s)
  );

  typedef struct packed {
    logic       locked;
    logic       mismatch;
    logic       fault;
    logic       wu;
    logic       wd;
    logic [7:0] err;
    logic [1:0] err_s;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  int         m_state;
  logic [3:0] m_pc;
  logic       m_pe, m_pu;
  int         m_consec, m_err, m_err_s;
  int         mm_tally, wu_tally, wd_tally;
  logic [3:0] cnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pc = '0; m_pe = 1'b0; m_pu = 1'b0;
    m_consec = 0; m_err = 0; m_err_s = 0;
  endtask

  // Apply one sample, predict the outputs for the following cycle, then compare after the edge.
  task automatic drive(input logic en, input logic ud, input logic [3:0] c, input logic clr);
    exp_t       e;
    exp_t       got;
    logic [3:0] pred;
    logic       bad;
    enable = en; up_down = ud; count = c; clear = clr;
    pred = m_pe ? (m_pu ? m_pc + 4'd1 : m_pc - 4'd1) : m_pc;
    e = '0;
    if (clr) begin
      m_state = 0; m_consec = 0; m_err = 0; m_err_s = 0;
    end else if (m_state == 0) begin
      m_state = 1; m_pc = c; m_pe = en; m_pu = ud;
    end else if (m_state == 1) begin
      bad = (c != pred);
      e.mismatch = bad;
      if (bad) begin
        if (m_err < 255) m_err++;
        if (m_err_s < 3) m_err_s++;
        m_consec++;
        if (m_consec == 3) m_state = 2;
      end else begin
        m_consec = 0;
        e.wu = WRAP_ON && m_pe && m_pu && (m_pc == 4'd15) && (c == 4'd0);
        e.wd = WRAP_ON && m_pe && !m_pu && (m_pc == 4'd0) && (c == 4'd15);
      end
      m_pc = c; m_pe = en; m_pu = ud;
    end
    e.locked = (m_state == 1);
    e.fault  = (m_state == 2);
    e.err    = m_err[7:0];
    e.err_s  = m_err_s[1:0];
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk("locked",      locked,      got.locked);
    chk("mismatch",    mismatch,    got.mismatch);
    chk("fault",       fault,       got.fault);
    chk("wrap_up",     wrap_up,     got.wu);
    chk("wrap_down",   wrap_down,   got.wd);
    chk("err_count",   err_count,   got.err);
    chk("err_count_s", err_count_s, got.err_s);
    chk("locked_s",    locked_s,    got.locked);
    chk("fault_s",     fault_s,     got.fault);
    if (mismatch)  mm_tally++;
    if (wrap_up)   wu_tally++;
    if (wrap_down) wd_tally++;
  endtask

  // Behave as the real counter: the value it shows moves after each enabled edge.
  task automatic run(input int n, input logic en, input logic ud);
    repeat (n) begin
      drive(en, ud, cnt, 1'b0);
      if (en) cnt = ud ? cnt + 4'd1 : cnt - 4'd1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"},   locked,    0);
    chk({tag, "_mismatch"}, mismatch,  0);
    chk({tag, "_err"},      err_count, 0);
    chk({tag, "_fault"},    fault,     0);
    chk({tag, "_wrap_up"},  wrap_up,   0);
    chk({tag, "_wrap_dn"},  wrap_down, 0);
    chk({tag, "_err_s"},    err_count_s, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; up_down = 1'b0; count = '0; clear = 1'b0;
    cnt = '0; mm_tally = 0; wu_tally = 0; wd_tally = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;

    // Free-running up count from 0 through one wrap
    run(20, 1'b1, 1'b1);
    chk("up_mismatches", mm_tally, 0);
    chk("up_err", err_count, 0);
    chk("up_wrap_pulses", wu_tally, WRAP_ON ? 1 : 0);

    // Down count across 0 -> 15
    mm_tally = 0; wd_tally = 0;
    drive(1'b1, 1'b0, 4'd2, 1'b1);
    cnt = 4'd1;
    run(6, 1'b1, 1'b0);
    chk("down_mismatches", mm_tally, 0);
    chk("down_wrap_pulses", wd_tally, WRAP_ON ? 1 : 0);

    // Hold at 5, then one glitch to 6 that the counter keeps
    drive(1'b0, 1'b0, 4'd5, 1'b1);
    mm_tally = 0; cnt = 4'd5;
    run(3, 1'b0, 1'b0);
    cnt = 4'd6;
    run(2, 1'b0, 1'b0);
    chk("hold_mismatches", mm_tally, 1);
    chk("hold_err", err_count, 1);
    drive(1'b0, 1'b0, 4'd9, 1'b0);
    drive(1'b0, 1'b0, 4'd12, 1'b0);
    chk("consec_cleared", fault, 0);

    // Three consecutive wrong samples latch the fault; tally then freezes
    drive(1'b0, 1'b0, 4'd12, 1'b1);
    drive(1'b0, 1'b0, 4'd12, 1'b0);
    drive(1'b0, 1'b0, 4'd12, 1'b0);
    drive(1'b0, 1'b0, 4'd9, 1'b0);
    drive(1'b0, 1'b0, 4'd3, 1'b0);
    drive(1'b0, 1'b0, 4'd7, 1'b0);
    chk("fault_err", err_count, 3);
    chk("fault_set", fault, 1);
    chk("fault_unlocked", locked, 0);
    drive(1'b0, 1'b0, 4'd1, 1'b0);
    drive(1'b0, 1'b0, 4'd14, 1'b0);
    chk("fault_err_frozen", err_count, 3);
    drive(1'b0, 1'b0, 4'd14, 1'b1);
    chk("clear_fault", fault, 0);
    chk("clear_err", err_count, 0);
    chk("clear_unlocked", locked, 0);
    drive(1'b0, 1'b0, 4'd14, 1'b0);
    chk("relock", locked, 1);

    // Alternating wrong/right samples: narrow tally saturates, no fault
    drive(1'b0, 1'b0, 4'd14, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, 1'b0, 4'((i * 3) % 16), 1'b0);
      drive(1'b0, 1'b0, 4'((i * 3) % 16), 1'b0);
    end
    chk("sat_err_s", err_count_s, 3);
    chk("sat_err", err_count, 10);
    chk("sat_no_fault", fault, 0);

    // Clear on the same edge as a wrong sample
    drive(1'b0, 1'b0, 4'd1, 1'b1);
    chk("clear_beats_mm", mismatch, 0);
    chk("clear_beats_err", err_count, 0);

    // Asynchronous reset while a mismatch pulse is showing
    drive(1'b0, 1'b0, 4'd1, 1'b0);
    drive(1'b0, 1'b0, 4'd1, 1'b0);
    drive(1'b0, 1'b0, 4'd4, 1'b0);
    chk("pre_reset_mm", mismatch, 1);
    reset_n = 1'b0;
    #2;
    chk_all_zero("async_reset");
    model_reset();
    sb_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive(1'b1, 1'b1, 4'd7, 1'b0);
    drive(1'b1, 1'b1, 4'd8, 1'b0);
    chk("post_reset_err", err_count, 0);
    chk("post_reset_locked", locked, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
